// File: rtl/and_tree_mc.sv
// Multi-class free-bitmap AND-tree level: first-free search and or_tree read-modify-write updates
// with full read-after-write forwarding. Define AND_TREE_MC_INIT_EN to clear every bitmap row after reset.
module and_tree_mc #(
  parameter int NUM_CLASS  = 4,
  parameter int LINE_WIDTH = 64,
  parameter int DEPTH      = 64,
  parameter int ROW_W      = $clog2(DEPTH),
  parameter int COL_W      = $clog2(LINE_WIDTH),
  parameter int CLS_W      = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1,
  parameter int ID_W       = 8,
  parameter int SIZE_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   srch_valid_in,
  input  logic [ID_W-1:0]        srch_id_in,
  input  logic [ROW_W-1:0]       srch_row_in,
  input  logic [CLS_W-1:0]       srch_cls_in,
  input  logic [SIZE_W-1:0]      srch_osize_in,
  output logic                   srch_valid_out,
  output logic [ID_W-1:0]        srch_id_out,
  output logic [ROW_W+COL_W-1:0] srch_index_out,
  output logic [CLS_W-1:0]       srch_cls_out,
  output logic [SIZE_W-1:0]      srch_osize_out,
  output logic                   srch_miss_out,
  input  logic                   upd_en_in,
  input  logic [ROW_W-1:0]       upd_row_in,
  input  logic [COL_W-1:0]       upd_col_in,
  input  logic [NUM_CLASS-1:0]   upd_bits_in,
  output logic                   fdt_upd_valid_out,
  output logic [ROW_W-1:0]       fdt_upd_row_out,
  output logic [NUM_CLASS-1:0]   fdt_upd_bits_out,
  output logic                   init_busy_out
);

  typedef logic [LINE_WIDTH-1:0]                line_t;
  typedef logic [NUM_CLASS-1:0][LINE_WIDTH-1:0] lines_t;

  localparam line_t ALL_ONES = {LINE_WIDTH{1'b1}};

  // Returns {miss, col}: lowest-index zero column, or {1, all-ones} when the line is full.
  function automatic logic [COL_W:0] first_zero(input line_t line);
    logic [COL_W:0] res;
    res = {1'b1, {COL_W{1'b1}}};
    for (int i = LINE_WIDTH - 1; i >= 0; i--) begin
      res = line[i] ? res : {1'b0, COL_W'(i)};
    end
    return res;
  endfunction

  line_t mem_r [NUM_CLASS][DEPTH];

  logic                 ready_s;
  logic                 srch_acc_s;
  logic                 upd_acc_s;
  logic                 wr_en_s;
  logic [ROW_W-1:0]     wr_row_s;
  lines_t               wr_data_s;

  // search stage registers
  logic                 s2_vld_r;
  logic [ID_W-1:0]      s2_id_r;
  logic [ROW_W-1:0]     s2_row_r;
  logic [CLS_W-1:0]     s2_cls_r;
  logic [SIZE_W-1:0]    s2_osize_r;
  line_t                s2_line_r;
  line_t                s1_line_s;
  line_t                s2_fwd_line_s;
  logic                 s3_vld_r;
  logic [ID_W-1:0]      s3_id_r;
  logic [ROW_W-1:0]     s3_row_r;
  logic [CLS_W-1:0]     s3_cls_r;
  logic [SIZE_W-1:0]    s3_osize_r;
  logic [COL_W-1:0]     s3_col_r;
  logic                 s3_miss_r;
  logic [COL_W:0]       s2_enc_s;

  // update stage registers
  lines_t               u1_lines_s;
  logic                 u2_vld_r;
  logic [ROW_W-1:0]     u2_row_r;
  logic [COL_W-1:0]     u2_col_r;
  logic [NUM_CLASS-1:0] u2_bits_r;
  lines_t               u2_lines_r;
  lines_t               u2_mod_s;
  logic                 u3_vld_r;
  logic [ROW_W-1:0]     u3_row_r;
  lines_t               u3_lines_r;
  logic [NUM_CLASS-1:0] u3_and_s;

  assign srch_acc_s = srch_valid_in & ready_s;
  assign upd_acc_s  = upd_en_in & ready_s;

`ifdef AND_TREE_MC_INIT_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } init_state_e;

  init_state_e      state_r;
  init_state_e      state_nxt_s;
  logic [ROW_W-1:0] init_row_r;
  logic [ROW_W-1:0] init_row_nxt_s;
  logic             busy_s;

  // init sweep state, row counter and registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      init_row_r    <= {ROW_W{1'b0}};
      init_busy_out <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      init_row_r    <= init_row_nxt_s;
      init_busy_out <= (state_nxt_s == ST_CLEAR);
    end
  end

  // init sweep next state; requests are only accepted once the sweep is done
  always_comb begin
    state_nxt_s    = state_r;
    init_row_nxt_s = init_row_r;
    busy_s         = 1'b0;
    ready_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s    = ST_CLEAR;
        init_row_nxt_s = {ROW_W{1'b0}};
      end
      ST_CLEAR: begin
        busy_s         = 1'b1;
        init_row_nxt_s = init_row_r + ROW_W'(1'b1);
        if (init_row_r == ROW_W'(DEPTH - 1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_DONE: begin
        ready_s = 1'b1;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // shared write port: init sweep has priority, U3 cannot be active while busy
  always_comb begin
    wr_en_s   = u3_vld_r;
    wr_row_s  = u3_row_r;
    wr_data_s = u3_lines_r;
    if (busy_s) begin
      wr_en_s   = 1'b1;
      wr_row_s  = init_row_r;
      wr_data_s = {NUM_CLASS{{LINE_WIDTH{1'b0}}}};
    end else begin
      wr_en_s   = u3_vld_r;
    end
  end
`else
  assign ready_s       = 1'b1;
  assign init_busy_out = 1'b0;

  // shared write port driven by U3 only
  always_comb begin
    wr_en_s   = u3_vld_r;
    wr_row_s  = u3_row_r;
    wr_data_s = u3_lines_r;
  end
`endif

  // bitmap storage; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        mem_r[k][wr_row_s] <= wr_data_s[k];
      end
    end
  end

  // S1 read, write-first so the row retiring from U3 this cycle is visible
  always_comb begin
    s1_line_s = ALL_ONES;
    if (int'(srch_cls_in) < NUM_CLASS) begin
      if (wr_en_s && (wr_row_s == srch_row_in)) begin
        s1_line_s = wr_data_s[srch_cls_in];
      end else begin
        s1_line_s = mem_r[srch_cls_in][srch_row_in];
      end
    end else begin
      s1_line_s = ALL_ONES;
    end
  end

  // S1 -> S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_r   <= 1'b0;
      s2_id_r    <= {ID_W{1'b0}};
      s2_row_r   <= {ROW_W{1'b0}};
      s2_cls_r   <= {CLS_W{1'b0}};
      s2_osize_r <= {SIZE_W{1'b0}};
      s2_line_r  <= {LINE_WIDTH{1'b0}};
    end else begin
      s2_vld_r <= srch_acc_s;
      if (srch_acc_s) begin
        s2_id_r    <= srch_id_in;
        s2_row_r   <= srch_row_in;
        s2_cls_r   <= srch_cls_in;
        s2_osize_r <= srch_osize_in;
        s2_line_r  <= s1_line_s;
      end
    end
  end

  // S2 forwarding: an update in U3 was accepted the cycle before this search,
  // the same-cycle update (now in U2) is deliberately not forwarded
  always_comb begin
    s2_fwd_line_s = s2_line_r;
    if (u3_vld_r && (u3_row_r == s2_row_r) && (int'(s2_cls_r) < NUM_CLASS)) begin
      s2_fwd_line_s = u3_lines_r[s2_cls_r];
    end else begin
      s2_fwd_line_s = s2_line_r;
    end
    s2_enc_s = first_zero(s2_fwd_line_s);
  end

  // S2 -> S3 register holding the encoded result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld_r   <= 1'b0;
      s3_id_r    <= {ID_W{1'b0}};
      s3_row_r   <= {ROW_W{1'b0}};
      s3_cls_r   <= {CLS_W{1'b0}};
      s3_osize_r <= {SIZE_W{1'b0}};
      s3_col_r   <= {COL_W{1'b0}};
      s3_miss_r  <= 1'b0;
    end else begin
      s3_vld_r <= s2_vld_r;
      if (s2_vld_r) begin
        s3_id_r    <= s2_id_r;
        s3_row_r   <= s2_row_r;
        s3_cls_r   <= s2_cls_r;
        s3_osize_r <= s2_osize_r;
        s3_col_r   <= s2_enc_s[COL_W-1:0];
        s3_miss_r  <= s2_enc_s[COL_W];
      end
    end
  end

  // S3 search outputs, all zero when no result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srch_valid_out <= 1'b0;
      srch_id_out    <= {ID_W{1'b0}};
      srch_index_out <= {(ROW_W+COL_W){1'b0}};
      srch_cls_out   <= {CLS_W{1'b0}};
      srch_osize_out <= {SIZE_W{1'b0}};
      srch_miss_out  <= 1'b0;
    end else if (s3_vld_r) begin
      srch_valid_out <= 1'b1;
      srch_id_out    <= s3_id_r;
      srch_index_out <= {s3_row_r, s3_col_r};
      srch_cls_out   <= s3_cls_r;
      srch_osize_out <= s3_osize_r;
      srch_miss_out  <= s3_miss_r;
    end else begin
      srch_valid_out <= 1'b0;
      srch_id_out    <= {ID_W{1'b0}};
      srch_index_out <= {(ROW_W+COL_W){1'b0}};
      srch_cls_out   <= {CLS_W{1'b0}};
      srch_osize_out <= {SIZE_W{1'b0}};
      srch_miss_out  <= 1'b0;
    end
  end

  // U1 read of every class, write-first like S1
  always_comb begin
    u1_lines_s = wr_data_s;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (wr_en_s && (wr_row_s == upd_row_in)) begin
        u1_lines_s[k] = wr_data_s[k];
      end else begin
        u1_lines_s[k] = mem_r[k][upd_row_in];
      end
    end
  end

  // U1 -> U2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u2_vld_r   <= 1'b0;
      u2_row_r   <= {ROW_W{1'b0}};
      u2_col_r   <= {COL_W{1'b0}};
      u2_bits_r  <= {NUM_CLASS{1'b0}};
      u2_lines_r <= {NUM_CLASS{{LINE_WIDTH{1'b0}}}};
    end else begin
      u2_vld_r <= upd_acc_s;
      if (upd_acc_s) begin
        u2_row_r   <= upd_row_in;
        u2_col_r   <= upd_col_in;
        u2_bits_r  <= upd_bits_in;
        u2_lines_r <= u1_lines_s;
      end
    end
  end

  // U2 modify, composing on top of the previous update still in U3
  always_comb begin
    if (u3_vld_r && (u3_row_r == u2_row_r)) begin
      u2_mod_s = u3_lines_r;
    end else begin
      u2_mod_s = u2_lines_r;
    end
    for (int k = 0; k < NUM_CLASS; k++) begin
      u2_mod_s[k][u2_col_r] = u2_bits_r[k];
    end
  end

  // U2 -> U3 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u3_vld_r   <= 1'b0;
      u3_row_r   <= {ROW_W{1'b0}};
      u3_lines_r <= {NUM_CLASS{{LINE_WIDTH{1'b0}}}};
    end else begin
      u3_vld_r <= u2_vld_r;
      if (u2_vld_r) begin
        u3_row_r   <= u2_row_r;
        u3_lines_r <= u2_mod_s;
      end
    end
  end

  // per-class all-used summary of the row being written
  always_comb begin
    u3_and_s = {NUM_CLASS{1'b0}};
    for (int k = 0; k < NUM_CLASS; k++) begin
      u3_and_s[k] = &u3_lines_r[k];
    end
  end

  // U3 fdt summary outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fdt_upd_valid_out <= 1'b0;
      fdt_upd_row_out   <= {ROW_W{1'b0}};
      fdt_upd_bits_out  <= {NUM_CLASS{1'b0}};
    end else if (u3_vld_r) begin
      fdt_upd_valid_out <= 1'b1;
      fdt_upd_row_out   <= u3_row_r;
      fdt_upd_bits_out  <= u3_and_s;
    end else begin
      fdt_upd_valid_out <= 1'b0;
      fdt_upd_row_out   <= {ROW_W{1'b0}};
      fdt_upd_bits_out  <= {NUM_CLASS{1'b0}};
    end
  end

endmodule

// File: tb/tb_and_tree_mc.sv
// Directed bench for and_tree_mc: default instance plus a NUM_CLASS=2/LINE_WIDTH=32/DEPTH=16 instance.
module tb_and_tree_mc;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        srch_valid_in;
  logic [7:0]  srch_id_in;
  logic [5:0]  srch_row_in;
  logic [1:0]  srch_cls_in;
  logic [2:0]  srch_osize_in;
  logic        srch_valid_out;
  logic [7:0]  srch_id_out;
  logic [11:0] srch_index_out;
  logic [1:0]  srch_cls_out;
  logic [2:0]  srch_osize_out;
  logic        srch_miss_out;
  logic        upd_en_in;
  logic [5:0]  upd_row_in;
  logic [5:0]  upd_col_in;
  logic [3:0]  upd_bits_in;
  logic        fdt_upd_valid_out;
  logic [5:0]  fdt_upd_row_out;
  logic [3:0]  fdt_upd_bits_out;
  logic        init_busy_out;

  logic        sw_srch_valid_in;
  logic [7:0]  sw_srch_id_in;
  logic [3:0]  sw_srch_row_in;
  logic        sw_srch_cls_in;
  logic [2:0]  sw_srch_osize_in;
  logic        sw_srch_valid_out;
  logic [7:0]  sw_srch_id_out;
  logic [8:0]  sw_srch_index_out;
  logic        sw_srch_cls_out;
  logic [2:0]  sw_srch_osize_out;
  logic        sw_srch_miss_out;
  logic        sw_upd_en_in;
  logic [3:0]  sw_upd_row_in;
  logic [4:0]  sw_upd_col_in;
  logic [1:0]  sw_upd_bits_in;
  logic        sw_fdt_upd_valid_out;
  logic [3:0]  sw_fdt_upd_row_out;
  logic [1:0]  sw_fdt_upd_bits_out;
  logic        sw_init_busy_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  and_tree_mc dut (
    .clk(clk), .rst_n(rst_n),
    .srch_valid_in(srch_valid_in), .srch_id_in(srch_id_in), .srch_row_in(srch_row_in),
    .srch_cls_in(srch_cls_in), .srch_osize_in(srch_osize_in),
    .srch_valid_out(srch_valid_out), .srch_id_out(srch_id_out), .srch_index_out(srch_index_out),
    .srch_cls_out(srch_cls_out), .srch_osize_out(srch_osize_out), .srch_miss_out(srch_miss_out),
    .upd_en_in(upd_en_in), .upd_row_in(upd_row_in), .upd_col_in(upd_col_in), .upd_bits_in(upd_bits_in),
    .fdt_upd_valid_out(fdt_upd_valid_out), .fdt_upd_row_out(fdt_upd_row_out),
    .fdt_upd_bits_out(fdt_upd_bits_out), .init_busy_out(init_busy_out)
  );

  and_tree_mc #(.NUM_CLASS(2), .LINE_WIDTH(32), .DEPTH(16)) dut_sw (
    .clk(clk), .rst_n(rst_n),
    .srch_valid_in(sw_srch_valid_in), .srch_id_in(sw_srch_id_in), .srch_row_in(sw_srch_row_in),
    .srch_cls_in(sw_srch_cls_in), .srch_osize_in(sw_srch_osize_in),
    .srch_valid_out(sw_srch_valid_out), .srch_id_out(sw_srch_id_out), .srch_index_out(sw_srch_index_out),
    .srch_cls_out(sw_srch_cls_out), .srch_osize_out(sw_srch_osize_out), .srch_miss_out(sw_srch_miss_out),
    .upd_en_in(sw_upd_en_in), .upd_row_in(sw_upd_row_in), .upd_col_in(sw_upd_col_in),
    .upd_bits_in(sw_upd_bits_in),
    .fdt_upd_valid_out(sw_fdt_upd_valid_out), .fdt_upd_row_out(sw_fdt_upd_row_out),
    .fdt_upd_bits_out(sw_fdt_upd_bits_out), .init_busy_out(sw_init_busy_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    srch_valid_in = 1'b0; srch_id_in = 8'd0; srch_row_in = 6'd0; srch_cls_in = 2'd0;
    srch_osize_in = 3'd0; upd_en_in = 1'b0; upd_row_in = 6'd0; upd_col_in = 6'd0; upd_bits_in = 4'd0;
    sw_srch_valid_in = 1'b0; sw_srch_id_in = 8'd0; sw_srch_row_in = 4'd0; sw_srch_cls_in = 1'b0;
    sw_srch_osize_in = 3'd0; sw_upd_en_in = 1'b0; sw_upd_row_in = 4'd0; sw_upd_col_in = 5'd0;
    sw_upd_bits_in = 2'd0;
  endtask

  task automatic srch(input logic [5:0] row, input logic [1:0] cls, input logic [7:0] id);
    srch_valid_in = 1'b1; srch_row_in = row; srch_cls_in = cls; srch_id_in = id; srch_osize_in = 3'd5;
  endtask

  task automatic upd(input logic [5:0] row, input logic [5:0] col, input logic [3:0] bits);
    upd_en_in = 1'b1; upd_row_in = row; upd_col_in = col; upd_bits_in = bits;
  endtask

  task automatic clear_row(input logic [5:0] row);
    for (int c = 0; c < 64; c++) begin
      upd(row, 6'(c), 4'b0000);
      cyc();
    end
    quiet();
    repeat (4) cyc();
  endtask

  task automatic check_srch(input string tag, input logic [11:0] idx, input logic miss, input logic [7:0] id);
    check({tag, "_valid"}, 64'(srch_valid_out), 64'd1);
    check({tag, "_index"}, 64'(srch_index_out), 64'(idx));
    check({tag, "_miss"}, 64'(srch_miss_out), 64'(miss));
    check({tag, "_id"}, 64'(srch_id_out), 64'(id));
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    cyc();
    cyc();
    while ((init_busy_out !== 1'b0 || sw_init_busy_out !== 1'b0) && n < 300) begin
      cyc();
      n++;
    end
    check("init_done", 64'({init_busy_out, sw_init_busy_out}), 64'd0);
  endtask

  initial begin
    int busy_cnt;
    rst_n = 1'b1;
    quiet();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_srch_valid", 64'(srch_valid_out), 64'd0);
    check("rst_index", 64'(srch_index_out), 64'd0);
    check("rst_miss", 64'(srch_miss_out), 64'd0);
    check("rst_fdt_valid", 64'(fdt_upd_valid_out), 64'd0);
    check("rst_fdt_bits", 64'(fdt_upd_bits_out), 64'd0);
    check("rst_busy", 64'(init_busy_out), 64'd0);
    rst_n = 1'b1;

`ifdef AND_TREE_MC_INIT_EN
    busy_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      cyc();
      if (init_busy_out === 1'b1) busy_cnt++;
      else if (busy_cnt != 0) break;
    end
    check("init_busy_cycles", 64'(busy_cnt), 64'd64);
`else
    busy_cnt = 0;
    repeat (3) cyc();
    check("busy_tied_low", 64'(init_busy_out), 64'd0);
`endif
    wait_init();

    clear_row(6'd3);
    clear_row(6'd5);
    clear_row(6'd9);

    // empty row: first column free
    srch(6'd5, 2'd2, 8'h11);
    cyc();
    quiet();
    cyc();
    cyc();
    check_srch("t1_row5", 12'd320, 1'b0, 8'h11);
    check("t1_cls", 64'(srch_cls_out), 64'd2);
    check("t1_osize", 64'(srch_osize_out), 64'd5);
    cyc();

    // three back-to-back updates to one row, then a search right behind them
    upd(6'd3, 6'd0, 4'b0001);
    cyc();
    upd(6'd3, 6'd1, 4'b0001);
    cyc();
    upd(6'd3, 6'd2, 4'b0001);
    cyc();
    quiet();
    srch(6'd3, 2'd0, 8'h22);
    check("t2_fdt0_valid", 64'(fdt_upd_valid_out), 64'd1);
    check("t2_fdt0_row", 64'(fdt_upd_row_out), 64'd3);
    check("t2_fdt0_bits", 64'(fdt_upd_bits_out), 64'd0);
    cyc();
    quiet();
    check("t2_fdt1_row", 64'(fdt_upd_row_out), 64'd3);
    check("t2_fdt1_bits", 64'(fdt_upd_bits_out), 64'd0);
    cyc();
    check("t2_fdt2_valid", 64'(fdt_upd_valid_out), 64'd1);
    check("t2_fdt2_bits", 64'(fdt_upd_bits_out), 64'd0);
    check("t2_early_valid", 64'(srch_valid_out), 64'd0);
    cyc();
    check_srch("t2_row3", 12'd195, 1'b0, 8'h22);
    check("t2_fdt_idle", 64'(fdt_upd_valid_out), 64'd0);
    cyc();
    check("t2_valid_drop", 64'(srch_valid_out), 64'd0);
    check("t2_miss_idle", 64'(srch_miss_out), 64'd0);

    // same-cycle search sees old row, next-cycle search sees the update
    upd(6'd9, 6'd0, 4'b0010);
    srch(6'd9, 2'd1, 8'h40);
    cyc();
    quiet();
    srch(6'd9, 2'd1, 8'h41);
    cyc();
    quiet();
    cyc();
    check_srch("t4_same_cycle", 12'd576, 1'b0, 8'h40);
    cyc();
    check_srch("t4_forwarded", 12'd577, 1'b0, 8'h41);
    cyc();

    // fill a whole row of class 3
    for (int i = 0; i < 67; i++) begin
      if (i < 64) upd(6'd7, 6'(i), 4'b1000);
      else quiet();
      if (i >= 3) begin
        check("t3_fdt_valid", 64'(fdt_upd_valid_out), 64'd1);
        check("t3_fdt_row", 64'(fdt_upd_row_out), 64'd7);
        check("t3_fdt_bits", 64'(fdt_upd_bits_out), (i == 66) ? 64'd8 : 64'd0);
      end
      cyc();
    end
    quiet();
    srch(6'd7, 2'd3, 8'h70);
    cyc();
    srch(6'd7, 2'd0, 8'h71);
    cyc();
    quiet();
    cyc();
    check_srch("t3_full_row", 12'hFFF & {6'd7, 6'h3F}, 1'b1, 8'h70);
    cyc();
    check_srch("t3_other_cls", 12'd448, 1'b0, 8'h71);
    cyc();

    // small-parameter instance: row 15 cols 0..30 used in class 0
    for (int c = 0; c < 32; c++) begin
      sw_upd_en_in = 1'b1; sw_upd_row_in = 4'd15; sw_upd_col_in = 5'(c);
      sw_upd_bits_in = (c < 31) ? 2'b01 : 2'b00;
      cyc();
    end
    quiet();
    cyc();
    cyc();
    check("sw_fdt_valid", 64'(sw_fdt_upd_valid_out), 64'd1);
    check("sw_fdt_row", 64'(sw_fdt_upd_row_out), 64'd15);
    check("sw_fdt_bits", 64'(sw_fdt_upd_bits_out), 64'd0);
    sw_srch_valid_in = 1'b1; sw_srch_row_in = 4'd15; sw_srch_cls_in = 1'b0; sw_srch_id_in = 8'h90;
    cyc();
    sw_srch_cls_in = 1'b1; sw_srch_id_in = 8'h91;
    cyc();
    quiet();
    cyc();
    check("sw_c0_valid", 64'(sw_srch_valid_out), 64'd1);
    check("sw_c0_index", 64'(sw_srch_index_out), 64'd511);
    check("sw_c0_miss", 64'(sw_srch_miss_out), 64'd0);
    cyc();
    check("sw_c1_index", 64'(sw_srch_index_out), 64'd480);
    check("sw_c1_id", 64'(sw_srch_id_out), 64'h91);
    cyc();

    // reset with two searches and two updates in flight
    srch(6'd3, 2'd0, 8'h50);
    upd(6'd3, 6'd10, 4'b0001);
    cyc();
    srch(6'd9, 2'd1, 8'h51);
    upd(6'd9, 6'd11, 4'b0010);
    cyc();
    quiet();
    cyc();
    check("t5_pre_srch_valid", 64'(srch_valid_out), 64'd1);
    check("t5_pre_fdt_valid", 64'(fdt_upd_valid_out), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_srch_valid", 64'(srch_valid_out), 64'd0);
    check("t5_index", 64'(srch_index_out), 64'd0);
    check("t5_id", 64'(srch_id_out), 64'd0);
    check("t5_fdt_valid", 64'(fdt_upd_valid_out), 64'd0);
    check("t5_fdt_row", 64'(fdt_upd_row_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cyc();
      check("t5_no_srch_pulse", 64'(srch_valid_out), 64'd0);
      check("t5_no_fdt_pulse", 64'(fdt_upd_valid_out), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/and_tree_mc.md
Name: and_tree_mc

Overview:
- Parametrised successor of the free-bitmap AND-tree level. Holds NUM_CLASS bitmaps, one per allocation size class, each DEPTH rows of LINE_WIDTH bits (1 = used).
- Serves fdt search requests by returning the first free bit's tree index for the requested class.
- Applies or_tree bit updates as a read-modify-write and reports per-row all-used summaries back to the fdt.
- New versus the previous generation: full read-after-write forwarding, a search-miss flag, and an optional init sweep.

Parameters:
- NUM_CLASS, 4, number of size classes / bitmaps.
- LINE_WIDTH, 64, bits per row; power of two, 8..256.
- DEPTH, 64, rows per bitmap; power of two.
- ROW_W, $clog2(DEPTH), row index width.
- COL_W, $clog2(LINE_WIDTH), column index width.
- CLS_W, $clog2(NUM_CLASS) (min 1), class index width.
- ID_W, 8, request id width.
- SIZE_W, 3, origin-size field width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- srch_valid_in  in  1  search request valid
- srch_id_in  in  ID_W  request id
- srch_row_in  in  ROW_W  row chosen by fdt
- srch_cls_in  in  CLS_W  aligned size class
- srch_osize_in  in  SIZE_W  original size, passed through
- srch_valid_out  out  1  search result valid
- srch_id_out  out  ID_W  id, passed through
- srch_index_out  out  ROW_W+COL_W  tree index = row*LINE_WIDTH + column
- srch_cls_out  out  CLS_W  class, passed through
- srch_osize_out  out  SIZE_W  origin size, passed through
- srch_miss_out  out  1  row had no free bit
- upd_en_in  in  1  or_tree update valid
- upd_row_in  in  ROW_W  row to update
- upd_col_in  in  COL_W  column to update
- upd_bits_in  in  NUM_CLASS  new bit value per class, bit k targets bitmap k
- fdt_upd_valid_out  out  1  summary valid
- fdt_upd_row_out  out  ROW_W  row summarised
- fdt_upd_bits_out  out  NUM_CLASS  bit k = AND of updated row in bitmap k
- init_busy_out  out  1  init sweep in progress (constant 0 without the optional feature)

Behaviour:
- Reset is asynchronous, active-low. All outputs reset to 0, all pipeline valids clear. Bitmap contents are not reset.
- No backpressure. One search and one update may be accepted every cycle, independently.
- Search pipeline, latency 3 (request in cycle t, result valid in t+3):
  - S1: synchronous read of row srch_row_in from bitmap srch_cls_in.
  - S2: select the forwarded line (see ordering below), run the lowest-index-zero priority encode, register the result.
  - S3: drive the outputs.
- Search results:
  - Column is the lowest-index 0 bit.
  - Index = {row, col}, no arithmetic carry.
  - If the line is all ones: srch_miss_out=1 and srch_index_out={row, all-ones col}.
  - srch_miss_out is 0 whenever srch_valid_out is 0.
- Update pipeline, latency 3 (in cycle t, fdt summary in t+3):
  - U1: read row upd_row_in from all NUM_CLASS bitmaps.
  - U2: for each k, set line[upd_col_in] = upd_bits_in[k], others unchanged; register the result.
  - U3: write every bitmap's row and drive the fdt summary.
- Ordering rule, enforced by forwarding from U2/U3 into S2 and U2:
  - Any read accepted in cycle t' observes every update accepted in cycle t < t'.
  - A search accepted in the same cycle as an update to the same row sees the pre-update value.
  - Back-to-back updates to the same row in cycles t, t+1, t+2 all compose. The final row contains all three modifications and each summary reflects the cumulative state.
- Out-of-range class index (≥ NUM_CLASS) reads as an all-ones line, so the search returns miss.
- Reset mid-operation clears all in-flight valids. No output fires for discarded requests. Partially updated rows are left as written.

Optional Feature:
- Macro: AND_TREE_MC_INIT_EN.
- With the macro, after reset deasserts, an FSM runs IDLE→CLEAR→DONE:
  - CLEAR writes all-zero to row r of every bitmap, for r = 0..DEPTH-1, one row per cycle.
  - init_busy_out=1 during CLEAR.
  - srch_valid_in and upd_en_in are ignored while busy. No outputs are generated for them.
  - init_busy_out falls in the cycle after row DEPTH-1 is written; the FSM then stays in DONE until reset.
- Without the macro: no FSM, init_busy_out tied 0, contents undefined until written.

Test Plan:
1. INIT_EN, DEPTH=64 → init_busy_out high exactly 64 cycles after rst_n rises. Then a search of row 5 class 2 returns index 320 (5*64+0), miss=0.
2. Updates set cols 0..2 of row 3 class 0 to 1 in consecutive cycles (upd_bits=4'b0001). Then a search of row 3 class 0 → index 195 with latency exactly 3. The three fdt summaries all show row 3 with bits 4'b0000.
3. 64 updates set all columns of row 7 class 3 → final summary 4'b1000. Then a search of row 7 class 3 → miss=1, index={7, 6'h3F}.
4. Update row 9 col 0 class 1 to 1 in cycle t, and search row 9 class 1 in t+1 → index 577 (forwarded). A search in the same cycle t → index 576.
5. Assert rst_n low with 2 searches and 2 updates in flight → all outputs 0 immediately. No valid pulses after release (without INIT_EN).
6. Parameter sweep NUM_CLASS=2, LINE_WIDTH=32, DEPTH=16: row 15 cols 0..30 used → search returns index 511 (15*32+31).
